dual_dispatch: RTL

//  Dual-issue dispatch stage directly downstream of the instruction queue. Each cycle examines the

---
 rtl/dual_dispatch_if.sv | 36 +++
 rtl/dual_dispatch.sv | 107 ++++++++++
 2 files changed

// File: rtl/dual_dispatch_if.sv
// dual_dispatch_if: bundle of the instruction-queue, writeback and issue
// signals around the dual-issue dispatch stage.
//   master : queue/backend side (drives instructions, writebacks, issue_en)
//   slave  : dispatch stage (drives stalls, issue slots, stall counter)
interface dual_dispatch_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      inst1;
  logic [31:0]      inst2;
  logic             in1_vld;
  logic             in2_vld;
  logic             issue_en;
  logic             wb1_en;
  logic [4:0]       wb1_reg;
  logic             wb2_en;
  logic [4:0]       wb2_reg;
  logic             stall1;
  logic             stall2;
  logic             iss1_vld;
  logic [31:0]      iss1_inst;
  logic             iss2_vld;
  logic [31:0]      iss2_inst;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output inst1, inst2, in1_vld, in2_vld, issue_en,
    output wb1_en, wb1_reg, wb2_en, wb2_reg,
    input  stall1, stall2, iss1_vld, iss1_inst, iss2_vld, iss2_inst, stall_cnt
  );

  modport slave (
    input  inst1, inst2, in1_vld, in2_vld, issue_en,
    input  wb1_en, wb1_reg, wb2_en, wb2_reg,
    output stall1, stall2, iss1_vld, iss1_inst, iss2_vld, iss2_inst, stall_cnt
  );
endinterface

// File: rtl/dual_dispatch.sv
// dual_dispatch: in-order dual-issue dispatch stage.
// Looks at the two oldest queue entries each cycle, checks them against a
// register busy scoreboard and against each other, and issues 0, 1 or 2
// instructions on registered issue slots. stall1/stall2 tell the queue how
// far to advance.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - dual_dispatch_if.slave: queue heads, writebacks, issue_en in;
//          stall1/stall2 (combinational), iss* slots and stall_cnt out
module dual_dispatch #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  dual_dispatch_if.slave bus
);

  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_nxt;
  logic             iss1_vld_q;
  logic             iss2_vld_q;
  logic [31:0]      iss1_inst_q;
  logic [31:0]      iss2_inst_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [5:0] op1, op2;
  logic [4:0] rs1, rt1, rs2, rt2;
  logic [4:0] dest1, dest2;
  logic       hz1, hz2;
  logic       pair_raw, pair_waw;
  logic       issue1, issue2;

  // Immediate / funct bits are irrelevant to hazard detection.
  logic unused_imm;
  assign unused_imm = ^{bus.inst1[10:0], bus.inst2[10:0]};

  // R-type (op==0) writes rd; every other op writes rt.
  assign op1   = bus.inst1[31:26];
  assign rs1   = bus.inst1[25:21];
  assign rt1   = bus.inst1[20:16];
  assign dest1 = (op1 == 6'd0) ? bus.inst1[15:11] : rt1;
  assign op2   = bus.inst2[31:26];
  assign rs2   = bus.inst2[25:21];
  assign rt2   = bus.inst2[20:16];
  assign dest2 = (op2 == 6'd0) ? bus.inst2[15:11] : rt2;

  // Register 0 is hard-wired and never reports busy.
  function automatic logic busy_at(input logic [NREG-1:0] sb, input logic [4:0] r);
    return (r != 5'd0) && sb[r];
  endfunction

  // rt is only a source for R-type; for I-type it is the destination and is
  // covered by the dest check.
  assign hz1 = busy_at(busy_q, rs1) | ((op1 == 6'd0) & busy_at(busy_q, rt1)) |
               busy_at(busy_q, dest1);
  assign hz2 = busy_at(busy_q, rs2) | ((op2 == 6'd0) & busy_at(busy_q, rt2)) |
               busy_at(busy_q, dest2);

  assign pair_raw = (dest1 != 5'd0) & ((rs2 == dest1) | ((op2 == 6'd0) & (rt2 == dest1)));
  assign pair_waw = (dest1 != 5'd0) & (dest2 == dest1);

  // Slot 2 can only go when slot 1 goes: issue stays strictly in order.
  assign issue1 = !rst & bus.issue_en & bus.in1_vld & !hz1;
  assign issue2 = issue1 & bus.in2_vld & !hz2 & !pair_raw & !pair_waw;

  assign bus.stall1 = !issue1;
  assign bus.stall2 = !issue2;

  // Clears first, then sets, so a register retired and re-claimed in the
  // same cycle stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.wb1_en) busy_nxt[bus.wb1_reg] = 1'b0;
    if (bus.wb2_en) busy_nxt[bus.wb2_reg] = 1'b0;
    if (issue1 && (dest1 != 5'd0)) busy_nxt[dest1] = 1'b1;
    if (issue2 && (dest2 != 5'd0)) busy_nxt[dest2] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      iss1_vld_q  <= 1'b0;
      iss2_vld_q  <= 1'b0;
      iss1_inst_q <= '0;
      iss2_inst_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q     <= busy_nxt;
      iss1_vld_q <= issue1;
      iss2_vld_q <= issue2;
      if (issue1) iss1_inst_q <= bus.inst1;
      if (issue2) iss2_inst_q <= bus.inst2;
      if (bus.in1_vld && !issue1 && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.iss1_vld  = iss1_vld_q;
  assign bus.iss2_vld  = iss2_vld_q;
  assign bus.iss1_inst = iss1_inst_q;
  assign bus.iss2_inst = iss2_inst_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
